// File: rtl/prog_loader.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : prog_loader
// Purpose : Buffers a 32-bit instruction stream in a small FIFO and writes it
//           into the pipeline's instruction memory at a paced rate. It then
//           releases the core to run and watches `value` for the pass flag.
//           Optional: define LOADER_TIMEOUT_EN to bound the RUN phase.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int DEPTH     = 4,
    parameter int MAX_WORDS = 1024,
    parameter int WR_GAP    = 0,
    parameter int TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        start,
    output logic [31:0] address,
    output logic [31:0] instruction,
    output logic        DataOrReg,
    output logic [31:0] check_address,
    input  logic [31:0] value,
    output logic [10:0] word_count,
    output logic        done,
    output logic        pass
);
    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          GW       = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [AW:0] FULL     = (AW + 1)'(DEPTH);
    localparam logic [10:0] LAST_IDX = 11'(MAX_WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, DONE} state_e;

    state_e         state_q, state_d;
    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [AW:0]    occ_q, occ_d;
    logic [GW-1:0]  gap_q;
    logic [10:0]    acc_q, wc_q;
    logic           s_ready_q, s_ready_d;
    logic           start_q, dor_q, done_q, pass_q, pass_d;
    logic [31:0]    address_q, instr_q;
    logic           accept, pop;
`ifdef LOADER_TIMEOUT_EN
    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] RUN_END = TW'(TIMEOUT - 1);
    logic [TW-1:0]  run_cnt_q;
`endif

    always_comb begin
        accept    = s_valid && s_ready_q;
        pop       = ((state_q == LOAD) || (state_q == DRAIN)) && (occ_q != '0) && (gap_q == '0);
        occ_d     = occ_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
        state_d   = state_q;
        pass_d    = pass_q;
        case (state_q)
            IDLE, LOAD: begin
                if (accept)
                    state_d = (s_last || (acc_q == LAST_IDX)) ? DRAIN : LOAD;
            end
            // occ_q==0 here means the final pop has already been on the bus for a cycle
            DRAIN: if (occ_q == '0) state_d = RUN;
            RUN: begin
                if (value == 32'd1) begin
                    state_d = DONE;
                    pass_d  = 1'b1;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (run_cnt_q == RUN_END) begin
                    state_d = DONE;
                end
`endif
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        // Registered ready reflects occupancy after this edge, so a full FIFO blocks even while popping
        s_ready_d = (state_d == IDLE) || ((state_d == LOAD) && (occ_d != FULL));
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wptr_q] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
            gap_q     <= '0;
            acc_q     <= '0;
            wc_q      <= '0;
            s_ready_q <= 1'b0;
            start_q   <= 1'b0;
            dor_q     <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            address_q <= '0;
            instr_q   <= NOP;
        end else begin
            state_q   <= state_d;
            occ_q     <= occ_d;
            s_ready_q <= s_ready_d;
            start_q   <= (state_d == LOAD) || (state_d == DRAIN);
            dor_q     <= (state_d == RUN) || (state_d == DONE);
            done_q    <= (state_d == DONE);
            pass_q    <= pass_d;
            if (accept) begin
                wptr_q <= wptr_q + 1'b1;
                acc_q  <= acc_q + 11'd1;
            end
            if (pop) begin
                rptr_q    <= rptr_q + 1'b1;
                address_q <= {21'd0, wc_q};
                instr_q   <= mem_q[rptr_q];
                wc_q      <= wc_q + 11'd1;
                gap_q     <= GW'(WR_GAP);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               run_cnt_q <= '0;
        else if (state_q == RUN)  run_cnt_q <= run_cnt_q + 1'b1;
        else                      run_cnt_q <= '0;
    end
`endif

    assign s_ready       = s_ready_q;
    assign start         = start_q;
    assign address       = address_q;
    assign instruction   = instr_q;
    assign DataOrReg     = dor_q;
    assign check_address = 32'd0;
    assign word_count    = wc_q;
    assign done          = done_q;
    assign pass          = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : tb_prog_loader
// Purpose : Directed self-checking bench for prog_loader. Three instances:
//           dut0 (WR_GAP=0), dut1 (WR_GAP=2), dut2 (MAX_WORDS=4).
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
module tb_prog_loader;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, s_valid, s_last;
    logic [31:0] s_data, value;
    logic [N-1:0]         s_ready, start, DataOrReg, done, pass;
    logic [N-1:0][31:0]   address, instruction, check_address;
    logic [N-1:0][10:0]   word_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wbuf [16];
    int acc_cyc [16];
    int wr_cyc  [16];
    logic [31:0] wr_addr [16];
    logic [31:0] wr_ins  [16];
    logic rdy_log   [64];
    logic start_log [64];
    int n_acc, n_wr;

    prog_loader #(.DEPTH(4), .MAX_WORDS(1024), .WR_GAP(0), .TIMEOUT(50)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[0]), .s_data(s_data),
        .s_last(s_last), .start(start[0]), .address(address[0]), .instruction(instruction[0]),
        .DataOrReg(DataOrReg[0]), .check_address(check_address[0]), .value(value),
        .word_count(word_count[0]), .done(done[0]), .pass(pass[0]));

    prog_loader #(.DEPTH(4), .MAX_WORDS(1024), .WR_GAP(2), .TIMEOUT(50)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[1]), .s_data(s_data),
        .s_last(s_last), .start(start[1]), .address(address[1]), .instruction(instruction[1]),
        .DataOrReg(DataOrReg[1]), .check_address(check_address[1]), .value(value),
        .word_count(word_count[1]), .done(done[1]), .pass(pass[1]));

    prog_loader #(.DEPTH(4), .MAX_WORDS(4), .WR_GAP(0), .TIMEOUT(50)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[2]), .s_data(s_data),
        .s_last(s_last), .start(start[2]), .address(address[2]), .instruction(instruction[2]),
        .DataOrReg(DataOrReg[2]), .check_address(check_address[2]), .value(value),
        .word_count(word_count[2]), .done(done[2]), .pass(pass[2]));

    task automatic do_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; value = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Offers wbuf[0..n-1] to instance d for a fixed number of cycles and logs events.
    task automatic drive_stream(input int d, input int n, input int last_idx, input int cycles);
        int   idx;
        int   wc_prev;
        logic rdy;
        idx = 0; n_acc = 0; n_wr = 0;
        wc_prev = int'(word_count[d]);
        for (int c = 0; c < cycles; c++) begin
            s_valid = (idx < n);
            s_data  = wbuf[idx];
            s_last  = (idx == last_idx);
            rdy     = s_ready[d];
            @(posedge clk); #1;
            if (s_valid && rdy) begin
                acc_cyc[n_acc] = c; n_acc++; idx++;
            end
            if (int'(word_count[d]) != wc_prev) begin
                wr_cyc[n_wr] = c; wr_addr[n_wr] = address[d]; wr_ins[n_wr] = instruction[d];
                n_wr++; wc_prev = int'(word_count[d]);
            end
            rdy_log[c]   = s_ready[d];
            start_log[c] = start[d];
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; value = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (start[d] !== 1'b0 || address[d] !== 32'd0 || instruction[d] !== 32'h13 ||
                DataOrReg[d] !== 1'b0 || check_address[d] !== 32'd0 || word_count[d] !== 11'd0 ||
                done[d] !== 1'b0 || pass[d] !== 1'b0 || s_ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: start=%b addr=%h instr=%h dor=%b chk=%h wc=%0d done=%b pass=%b rdy=%b; required 0 0 00000013 0 0 0 0 0 0",
                         d, start[d], address[d], instruction[d], DataOrReg[d], check_address[d],
                         word_count[d], done[d], pass[d], s_ready[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (s_ready[0] !== 1'b1 || start[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: s_ready=%b start=%b; required 1 0", s_ready[0], start[0]);
        end
    endtask

    task automatic test_basic_load();
        wbuf[0] = 32'h00500093; wbuf[1] = 32'h00300113; wbuf[2] = 32'h002081B3;
        do_reset();
        drive_stream(0, 3, 2, 8);
        n_checks++;
        if (n_acc !== 3 || n_wr !== 3) begin
            n_fail++;
            $display("FAIL basic_counts: accepted=%0d written=%0d; required 3 3", n_acc, n_wr);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (wr_cyc[i] !== i + 1 || wr_addr[i] !== 32'(i) || wr_ins[i] !== wbuf[i]) begin
                n_fail++;
                $display("FAIL basic_write%0d: cycle=%0d addr=%0d instr=%h; required %0d %0d %h",
                         i, wr_cyc[i], wr_addr[i], wr_ins[i], i + 1, i, wbuf[i]);
            end
        end
        n_checks++;
        if (start_log[3] !== 1'b1 || start_log[4] !== 1'b0 || word_count[0] !== 11'd3) begin
            n_fail++;
            $display("FAIL basic_start_fall: start@3=%b start@4=%b wc=%0d; required 1 0 3",
                     start_log[3], start_log[4], word_count[0]);
        end
    endtask

    task automatic test_run_pass();
        int bad;
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            if (DataOrReg[0] !== 1'b1 || check_address[0] !== 32'd0 || done[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL run_outputs: %0d bad RUN cycles; required 0 (dor=%b chk=%h done=%b)",
                     bad, DataOrReg[0], check_address[0], done[0]);
        end
        value = 32'd1;
        @(posedge clk); #1;
        value = 32'd0;
        n_checks++;
        if (done[0] !== 1'b1 || pass[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_rise: done=%b pass=%b; required 1 1", done[0], pass[0]);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (done[0] !== 1'b1 || pass[0] !== 1'b1 || address[0] !== 32'd2 || instruction[0] !== 32'h002081B3 ||
            start[0] !== 1'b0 || DataOrReg[0] !== 1'b1 || s_ready[0] !== 1'b0 || word_count[0] !== 11'd3) begin
            n_fail++;
            $display("FAIL done_frozen: done=%b pass=%b addr=%0d instr=%h start=%b dor=%b rdy=%b wc=%0d; required 1 1 2 002081b3 0 1 0 3",
                     done[0], pass[0], address[0], instruction[0], start[0], DataOrReg[0], s_ready[0], word_count[0]);
        end
    endtask

    task automatic test_back_to_back_gap();
        int exp_acc [8];
        exp_acc = '{0, 1, 2, 3, 4, 5, 8, 11};
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hA000_0000 + 32'(i * 17);
        do_reset();
        drive_stream(1, 8, 7, 40);
        n_checks++;
        if (n_acc !== 8 || n_wr !== 8) begin
            n_fail++;
            $display("FAIL gap_counts: accepted=%0d written=%0d; required 8 8", n_acc, n_wr);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (acc_cyc[i] !== exp_acc[i] || wr_cyc[i] !== 3 * i + 1 || wr_addr[i] !== 32'(i) || wr_ins[i] !== wbuf[i]) begin
                n_fail++;
                $display("FAIL gap_word%0d: acc_cycle=%0d wr_cycle=%0d addr=%0d instr=%h; required %0d %0d %0d %h",
                         i, acc_cyc[i], wr_cyc[i], wr_addr[i], wr_ins[i], exp_acc[i], 3 * i + 1, i, wbuf[i]);
            end
        end
        n_checks++;
        if (rdy_log[5] !== 1'b0 || rdy_log[6] !== 1'b0 || rdy_log[7] !== 1'b1 || rdy_log[8] !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_ready: rdy@5..8=%b%b%b%b; required 0010",
                     rdy_log[5], rdy_log[6], rdy_log[7], rdy_log[8]);
        end
        n_checks++;
        if (start_log[22] !== 1'b1 || start_log[23] !== 1'b0 || word_count[1] !== 11'd8) begin
            n_fail++;
            $display("FAIL gap_start_fall: start@22=%b start@23=%b wc=%0d; required 1 0 8",
                     start_log[22], start_log[23], word_count[1]);
        end
    endtask

    task automatic test_max_words();
        for (int i = 0; i < 6; i++) wbuf[i] = 32'hB000_0000 + 32'(i);
        do_reset();
        drive_stream(2, 6, -1, 12);
        n_checks++;
        if (n_acc !== 4 || n_wr !== 4 || acc_cyc[3] !== 3) begin
            n_fail++;
            $display("FAIL max_accept: accepted=%0d written=%0d last_acc_cycle=%0d; required 4 4 3",
                     n_acc, n_wr, acc_cyc[3]);
        end
        n_checks++;
        if (s_ready[2] !== 1'b0 || word_count[2] !== 11'd4 || start[2] !== 1'b0 || DataOrReg[2] !== 1'b1 ||
            address[2] !== 32'd3 || instruction[2] !== 32'hB000_0003) begin
            n_fail++;
            $display("FAIL max_run: rdy=%b wc=%0d start=%b dor=%b addr=%0d instr=%h; required 0 4 0 1 3 b0000003",
                     s_ready[2], word_count[2], start[2], DataOrReg[2], address[2], instruction[2]);
        end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        wbuf[0] = 32'h00000013;
        do_reset();
        drive_stream(0, 1, 0, 3);
        n_checks++;
        if (start[0] !== 1'b0 || DataOrReg[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_run_entry: start=%b dor=%b; required 0 1", start[0], DataOrReg[0]);
        end
`ifdef LOADER_TIMEOUT_EN
        for (int c = 0; c < 49; c++) begin
            @(posedge clk); #1;
            if (done[0] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL timeout_early: done high in %0d of 49 cycles; required 0", bad);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done[0] !== 1'b1 || pass[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_expire: done=%b pass=%b; required 1 0", done[0], pass[0]);
        end
`else
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (done[0] !== 1'b0 || pass[0] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL no_timeout: done/pass high in %0d of 200 cycles; required 0", bad);
        end
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) wbuf[i] = 32'hC000_0000 + 32'(i);
        do_reset();
        drive_stream(1, 5, 4, 2);
        n_checks++;
        if (n_acc !== 2 || start[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: accepted=%0d start=%b; required 2 1", n_acc, start[1]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (start[1] !== 1'b0 || address[1] !== 32'd0 || instruction[1] !== 32'h13 || word_count[1] !== 11'd0 ||
            s_ready[1] !== 1'b0 || DataOrReg[1] !== 1'b0 || done[1] !== 1'b0 || pass[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_reset: start=%b addr=%0d instr=%h wc=%0d rdy=%b dor=%b done=%b pass=%b; required 0 0 00000013 0 0 0 0 0",
                     start[1], address[1], instruction[1], word_count[1], s_ready[1], DataOrReg[1], done[1], pass[1]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) wbuf[i] = 32'hD000_0000 + 32'(i * 3);
        drive_stream(1, 5, 4, 24);
        n_checks++;
        if (n_wr !== 5 || word_count[1] !== 11'd5 || wr_cyc[0] !== 1) begin
            n_fail++;
            $display("FAIL reload_counts: written=%0d wc=%0d first_write_cycle=%0d; required 5 5 1",
                     n_wr, word_count[1], wr_cyc[0]);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (wr_addr[i] !== 32'(i) || wr_ins[i] !== wbuf[i]) begin
                n_fail++;
                $display("FAIL reload_word%0d: addr=%0d instr=%h; required %0d %h", i, wr_addr[i], wr_ins[i], i, wbuf[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_run_pass();
        test_back_to_back_gap();
        test_max_words();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Program loader that sits directly upstream of `pipeline` and drives its instruction-load and result-check ports. It accepts a stream of 32-bit instruction words over a valid/ready handshake and buffers them in a small FIFO. It writes them into the pipeline's instruction memory through `start`/`address`/`instruction` at a paced rate. It then releases the core to run and watches the pipeline's `value` output for the pass flag.

## Interface

Parameters:
- `DEPTH`, 4: FIFO depth in words; power of two, at least 2.
- `MAX_WORDS`, 1024: instruction-memory capacity in words.
- `WR_GAP`, 0: idle cycles inserted between consecutive memory writes.
- `TIMEOUT`, 4096: maximum RUN cycles (used only with `LOADER_TIMEOUT_EN`).

Ports:
- `clk`  in  1  clock; all flops on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  32  instruction word.
- `s_last`  in  1  marks the final word of the program.
- `start`  out  1  to `pipeline.start`; 1 = load mode, 0 = run.
- `address`  out  32  to `pipeline.address`; word index.
- `instruction`  out  32  to `pipeline.instruction`.
- `DataOrReg`  out  1  to `pipeline.DataOrReg`.
- `check_address`  out  32  to `pipeline.check_address`.
- `value`  in  32  from `pipeline.value`.
- `word_count`  out  11  number of words written to the pipeline.
- `done`  out  1  program finished; sticky.
- `pass`  out  1  valid while `done`=1; 1 = `value` reached 1.

## Operation

- States: IDLE, LOAD, DRAIN, RUN, DONE.
- Reset values of every output:
  - `start`=0, `address`=0, `instruction`=0x00000013 (NOP).
  - `DataOrReg`=0, `check_address`=0, `word_count`=0.
  - `done`=0, `pass`=0, `s_ready`=0.
- IDLE:
  - `s_ready`=1.
  - On the first accepted word (`s_valid`&`s_ready`), go to LOAD; `start` goes to 1.
- LOAD:
  - `s_ready` = FIFO not full AND (accepted words < `MAX_WORDS`).
  - On accepting a word with `s_last`=1, go to DRAIN.
  - When the `MAX_WORDS`-th word is accepted, go to DRAIN whatever `s_last` is; further input is refused.
- Write path, active in LOAD and DRAIN:
  - When the FIFO is non-empty and the gap counter is 0, pop one word.
  - On the pop, register `address`=`word_count`, `instruction`=word, and `word_count`+1.
  - Reload the gap counter with `WR_GAP` on each pop.
  - On cycles with no pop, `address`/`instruction` hold their values. The pipeline rewrites the same word, which is idempotent.
- DRAIN:
  - `s_ready`=0.
  - When the FIFO is empty and the last pop has been presented for one cycle, go to RUN.
- RUN:
  - `start`=0, `DataOrReg`=1, `check_address`=0.
  - When `value`==1 is sampled, go to DONE with `pass`=1.
- DONE:
  - `done`=1; all outputs are frozen.
  - Input is refused; only `rst_n` leaves this state.
- Simultaneous push and pop on the same edge are both honoured; FIFO occupancy is unchanged.
- Reset mid-operation:
  - All state clears immediately, including FIFO pointers and `word_count`.
  - Instruction-memory contents already written are not touched.

## Timing

- Word accepted at edge k into an empty FIFO with the gap counter at 0:
  - popped at edge k+1.
  - visible on `address`/`instruction` after edge k+1.
- Steady-state write rate is one word every `WR_GAP`+1 cycles.
- `s_ready` is registered and derived from occupancy at the previous edge. A full FIFO deasserts it even if a pop occurs in the same cycle.
- The last word is held on the bus for at least one cycle with `start`=1. `start` falls at the following edge.
- `value` is sampled every RUN cycle. `done`/`pass` rise one edge after `value`==1 is seen.

## Configuration

- `LOADER_TIMEOUT_EN` defined:
  - A RUN-cycle counter is compiled in.
  - After `TIMEOUT` RUN cycles without `value`==1, go to DONE with `pass`=0.
  - If `value`==1 and timeout coincide on the same cycle, `pass`=1.
- `LOADER_TIMEOUT_EN` not defined:
  - No counter is built.
  - RUN waits indefinitely; `pass` can only become 1.

## Test plan

- Stream 3 words (0x00500093, 0x00300113, 0x002081B3) back-to-back, last on word 3, `WR_GAP`=0 -> addresses 0,1,2 on consecutive cycles; `word_count`=3; `start` falls one cycle after address 2.
- `WR_GAP`=2, DEPTH=4, 8 words offered continuously -> a write every 3 cycles; `s_ready` drops when 4 words are buffered; all 8 are written in order.
- Model drives `value`=1 for one cycle 20 cycles into RUN -> `done`=1 and `pass`=1 one edge later; `DataOrReg`=1 and `check_address`=0 throughout RUN.
- `MAX_WORDS`=4 with 6 words and no `s_last` -> only 4 are accepted; `s_ready`=0 afterwards; `word_count`=4; RUN is entered.
- With `LOADER_TIMEOUT_EN` and `TIMEOUT`=50, `value` held at 0 -> `done`=1, `pass`=0 after 50 RUN cycles; without the macro, `done` stays 0 for 200 cycles.
- Assert `rst_n`=0 after 2 of 5 words -> all outputs return to reset values immediately; a reload of 5 words restarts from address 0.
